// File: rtl/apb_completer.sv
// APB completer with a small register bank, programmable wait states and PSLVERR.
// Register 0 is brought out as ctrl_out; the top two addresses are read-only WCNT and ID.
module apb_completer #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                NUM_REGS    = 16,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = 'hA5
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic [DATA_W-1:0] ctrl_out
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int NUM_RW = NUM_REGS - 2;

  localparam logic [ADDR_W:0]  NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] WCNT_IDX   = IDX_W'(NUM_REGS - 2);
  localparam logic [IDX_W-1:0] ID_IDX     = IDX_W'(NUM_REGS - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wcnt_q, wcnt_d;

  logic [NUM_RW-1:0][DATA_W-1:0] regs_q, regs_d;

  logic              xfer_done;
  logic              in_range;
  logic              is_rw;
  logic              err;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rdata;

  // Completion is purely combinational so pready lands in the right access cycle.
  assign xfer_done = (state_q == S_ACCESS) && psel && penable && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: no write, no response.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (penable) begin
          if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
          else               state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Any non-zero upper address bit pushes the address out of range.
  assign in_range = {1'b0, addr_q} < NUM_REGS_A;
  assign idx      = addr_q[IDX_W-1:0];
  assign is_rw    = in_range && (idx < WCNT_IDX);
  assign err      = !in_range || (write_q && !is_rw);
  assign wr_en    = xfer_done && write_q && !err;

  always_comb begin
    rdata = '0;
    if (idx == ID_IDX) begin
      rdata = ID_VALUE;
    end else if (idx == WCNT_IDX) begin
      rdata = DATA_W'(wcnt_q);
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (idx == IDX_W'(i)) rdata = regs_q[i];
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (idx == IDX_W'(i)) regs_d[i] = wdata_q;
      end
    end
  end

  assign wcnt_d = wr_en ? wcnt_q + 8'd1 : wcnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wcnt_q  <= 8'd0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      regs_q  <= regs_d;
    end
  end

  assign pready   = xfer_done;
  assign pslverr  = xfer_done && err;
  assign prdata   = (xfer_done && !write_q && !err) ? rdata : '0;
  assign ctrl_out = regs_q[0];

endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: one instance with 2 wait states, one with zero wait states,
// each on its own APB bus, checked against vector tables and a register-map model.
module tb_apb_completer;

  logic       pclk;
  logic       presetn;
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic       pready  [2];
  logic [7:0] prdata  [2];
  logic       pslverr [2];
  logic [7:0] ctrl_out[2];

  int total = 0;
  int bad   = 0;

  apb_completer #(.WAIT_CYCLES(2)) u_w2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]),
    .prdata(prdata[0]), .pslverr(pslverr[0]), .ctrl_out(ctrl_out[0]));

  apb_completer #(.WAIT_CYCLES(0)) u_w0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]),
    .prdata(prdata[1]), .pslverr(pslverr[1]), .ctrl_out(ctrl_out[1]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference register map: 14 r/w registers, write counter, ID.
  logic [7:0] mem  [2][16];
  logic [7:0] wcnt [2];

  typedef struct {
    int         d;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    bit         exp_err;
    bit         gap;
    logic [7:0] exp_ctrl;
  } vec_t;

  vec_t tab[$];

  function automatic int lat_exp(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mem[d][i] = 8'h00;
      wcnt[d] = 8'h00;
    end
  endtask

  task automatic model(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                       output logic [7:0] rd, output bit er);
    er = (a >= 8'd16) || (wr && a >= 8'd14);
    rd = 8'h00;
    if (!er) begin
      if (wr) begin
        mem[d][a[3:0]] = wd;
        wcnt[d] = wcnt[d] + 8'd1;
      end else if (a == 8'd15) rd = 8'hA5;
      else if (a == 8'd14)     rd = wcnt[d];
      else                     rd = mem[d][a[3:0]];
    end
  endtask

  task automatic add(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] rd, input bit er, input bit gap, input logic [7:0] ctrl);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = a; v.wdata = wd;
    v.exp_rd = rd; v.exp_err = er; v.gap = gap; v.exp_ctrl = ctrl;
    tab.push_back(v);
  endtask

  task automatic idle(input int d);
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  // Full SETUP/ACCESS transfer; returns at the negedge of the completion cycle.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output bit er);
    int n;
    bit got;
    @(posedge pclk); #1;
    psel[1-d] = 1'b0; penable[1-d] = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(negedge pclk);
    check($sformatf("setup_pready d%0d", d), pready[d], 0);
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    // Address/data wander during access and must be ignored.
    paddr[d] = 8'($urandom); pwdata[d] = 8'($urandom);
    n = 1; got = 0; rd = 8'h00; er = 0;
    while (!got && n <= 40) begin
      @(negedge pclk);
      if (pready[d]) begin
        got = 1; rd = prdata[d]; er = pslverr[d];
      end else begin
        n++;
        @(posedge pclk); #1;
      end
    end
    if (!got) begin
      check($sformatf("timeout d%0d a=%0h", d, a), 0, 1);
      psel[d] = 1'b0; penable[d] = 1'b0;
    end else begin
      check($sformatf("latency d%0d a=%0h", d, a), n, lat_exp(d));
    end
  endtask

  task automatic run_op(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input bit has_exp, input logic [7:0] t_rd, input bit t_er);
    logic [7:0] rd, m_rd;
    bit er, m_er;
    xfer(d, wr, a, wd, rd, er);
    model(d, wr, a, wd, m_rd, m_er);
    if (has_exp) begin
      m_rd = t_rd; m_er = t_er;
    end
    check($sformatf("pslverr d%0d wr=%0d a=%0h", d, wr, a), er, m_er);
    if (!wr) check($sformatf("prdata d%0d a=%0h", d, a), rd, m_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    bit er;
    bit acc;

    presetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0; pwdata[d] = 0;
    end
    model_reset();

    add(0, 1, 8'h00, 8'h3C, 8'h00, 0, 1, 8'h3C);
    add(0, 0, 8'h00, 8'h00, 8'h3C, 0, 1, 8'h3C);
    add(0, 0, 8'h0F, 8'h00, 8'hA5, 0, 1, 8'h3C);
    add(0, 1, 8'h0F, 8'h11, 8'h00, 1, 1, 8'h3C);
    add(0, 0, 8'h0F, 8'h00, 8'hA5, 0, 1, 8'h3C);
    add(0, 1, 8'h05, 8'h99, 8'h00, 0, 1, 8'h3C);
    add(0, 0, 8'h0E, 8'h00, 8'h02, 0, 1, 8'h3C);
    add(0, 0, 8'h20, 8'h00, 8'h00, 1, 1, 8'h3C);
    add(0, 1, 8'h10, 8'h55, 8'h00, 1, 1, 8'h3C);
    add(0, 1, 8'h0E, 8'h07, 8'h00, 1, 1, 8'h3C);
    add(0, 0, 8'h8F, 8'h00, 8'h00, 1, 1, 8'h3C);
    add(0, 0, 8'h0E, 8'h00, 8'h02, 0, 1, 8'h3C);
    add(0, 0, 8'h05, 8'h00, 8'h99, 0, 1, 8'h3C);
    add(1, 1, 8'h02, 8'h01, 8'h00, 0, 0, 8'h00);
    add(1, 1, 8'h03, 8'h02, 8'h00, 0, 0, 8'h00);
    add(1, 0, 8'h02, 8'h00, 8'h01, 0, 0, 8'h00);
    add(1, 0, 8'h03, 8'h00, 8'h02, 0, 0, 8'h00);
    add(1, 1, 8'h00, 8'h5A, 8'h00, 0, 1, 8'h5A);
    add(1, 0, 8'h0E, 8'h00, 8'h03, 0, 1, 8'h5A);

    // Reset and idle
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 2; d++)
      check($sformatf("in_reset d%0d", d), {pready[d], pslverr[d], prdata[d], ctrl_out[d]}, 0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    acc = 0;
    repeat (10) begin
      @(negedge pclk);
      for (int d = 0; d < 2; d++)
        acc = acc | pready[d] | pslverr[d] | (|prdata[d]) | (|ctrl_out[d]);
    end
    check("idle_outputs", acc, 0);

    // Directed vectors
    foreach (tab[i]) begin
      run_op(tab[i].d, tab[i].wr, tab[i].addr, tab[i].wdata, 1, tab[i].exp_rd, tab[i].exp_err);
      if (tab[i].gap) begin
        idle(tab[i].d);
        @(negedge pclk);
        check($sformatf("ctrl_out vec%0d", i), ctrl_out[tab[i].d], tab[i].exp_ctrl);
      end
    end
    idle(1);

    // Abort: psel drops during a wait cycle, write must not land
    @(posedge pclk); #1;
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 8'h01; pwdata[0] = 8'h44;
    @(posedge pclk); #1;
    penable[0] = 1;
    @(negedge pclk);
    check("abort_wait_pready", pready[0], 0);
    @(posedge pclk); #1;
    psel[0] = 0; penable[0] = 0;
    @(negedge pclk);
    check("abort_no_pready", pready[0], 0);
    run_op(0, 0, 8'h01, 8'h00, 0, 8'h00, 0);
    run_op(0, 0, 8'h0E, 8'h00, 0, 8'h00, 0);

    // Reset during the access phase of a write
    @(posedge pclk); #1;
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 8'h01; pwdata[0] = 8'h77;
    @(posedge pclk); #1;
    penable[0] = 1;
    @(negedge pclk); #1;
    presetn = 1'b0;
    #1;
    check("midrst_pready", pready[0], 0);
    check("midrst_ctrl", ctrl_out[0], 0);
    psel[0] = 0; penable[0] = 0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    model_reset();
    run_op(0, 0, 8'h01, 8'h00, 1, 8'h00, 0);
    run_op(0, 0, 8'h0E, 8'h00, 1, 8'h00, 0);
    run_op(1, 0, 8'h02, 8'h00, 1, 8'h00, 0);

    // Randomized traffic against the model
    repeat (120) begin
      int d;
      bit wr;
      logic [7:0] a, wd;
      d  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
      wd = 8'($urandom);
      run_op(d, wr, a, wd, 0, 8'h00, 0);
      if ($urandom_range(0, 2) == 0) begin
        idle(d);
        @(negedge pclk);
        check($sformatf("rand_ctrl d%0d", d), ctrl_out[d], mem[d][0]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      model(d, 0, 8'h0E, 8'h00, rd, er);
      run_op(d, 0, 8'h0E, 8'h00, 0, 8'h00, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
